// File: rtl/m_fifo_frame_gen_w11.sv
// Frame source for the 11-bit link-layer stream feeding the short FIFO.
// Word layout: [7:0] payload, [8] SOF, [9] EOF, [10] error.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, busy low
// SEND  | presenting frame words, advancing on src_rdy_o & dst_rdy_i
// GAP   | post-frame idle time, busy high, start ignored
module m_fifo_frame_gen_w11 #(
    parameter int LEN_W      = 11,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       seed,
    input  logic             err_inject,
    output logic [10:0]      dataout,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Gap timer is a down-counter loaded with GAP_CYCLES-1; terminal count is zero.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         seed_q, seed_d;
    logic               err_q, err_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [10:0]        dataout_d;
    logic               src_rdy_d, busy_d, done_d;
    logic [CNT_W-1:0]   frame_count_d;

    logic [LEN_W-1:0]   len_start;
    logic               xfer;
    logic               last;

    // A zero length request still produces one word carrying both SOF and EOF.
    assign len_start = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign xfer      = src_rdy_o & dst_rdy_i;
    assign last      = (cnt_q == len_q - LEN_W'(1));

    function automatic logic [10:0] make_word(input logic [7:0]       s,
                                              input logic [LEN_W-1:0] k,
                                              input logic [LEN_W-1:0] l,
                                              input logic             e);
        logic eof;
        eof = (k == l - LEN_W'(1));
        return {e & eof, eof, (k == '0), s + 8'(k)};
    endfunction

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_d       = state;
        len_d         = len_q;
        cnt_d         = cnt_q;
        seed_d        = seed_q;
        err_d         = err_q;
        gap_d         = gap_q;
        dataout_d     = dataout;
        src_rdy_d     = src_rdy_o;
        busy_d        = busy;
        done_d        = 1'b0;
        frame_count_d = frame_count;

        case (state)
            IDLE: begin
                if (start) begin
                    len_d     = len_start;
                    seed_d    = seed;
                    err_d     = err_inject;
                    cnt_d     = '0;
                    dataout_d = make_word(seed, '0, len_start, err_inject);
                    src_rdy_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last) begin
                        src_rdy_d     = 1'b0;
                        done_d        = 1'b1;
                        frame_count_d = frame_count + CNT_W'(1);
                        if (GAP_CYCLES == 0) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d     = cnt_q + LEN_W'(1);
                        dataout_d = make_word(seed_q, cnt_q + LEN_W'(1), len_q, err_q);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; clear returns everything to reset values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            err_q       <= 1'b0;
            gap_q       <= '0;
            dataout     <= '0;
            src_rdy_o   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else if (clear) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            err_q       <= 1'b0;
            gap_q       <= '0;
            dataout     <= '0;
            src_rdy_o   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            dataout     <= dataout_d;
            src_rdy_o   <= src_rdy_d;
            busy        <= busy_d;
            done        <= done_d;
            frame_count <= frame_count_d;
        end
    end

endmodule

// File: doc/m_fifo_frame_gen_w11.md
Name: m_fifo_frame_gen_w11

Overview:
- Frame source that writes the 11-bit link-layer stream into the input side of the short FIFO (m_fifo_short_w11).
- It drives datain/src_rdy_i and obeys dst_rdy_o.
- Generates one frame per start request with programmable length, deterministic payload, SOF/EOF marking and optional error marking, for MAC transmit-path and FIFO bring-up.
- Word layout: bits [7:0] payload byte, bit 8 SOF, bit 9 EOF, bit 10 error.

Parameters:
- LEN_W, 11, width of frame_len (frame length in bytes).
- GAP_CYCLES, 4, idle cycles inserted after each frame before the next start is accepted (0 allowed).
- CNT_W, 16, width of frame_count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear, active-high.
- start  input  1  one-cycle request to generate one frame.
- frame_len  input  LEN_W  frame length in bytes, sampled on accepted start.
- seed  input  8  first payload byte, sampled on accepted start.
- err_inject  input  1  sampled on accepted start; marks the EOF word with the error bit.
- dataout  output  11  stream word to FIFO datain.
- src_rdy_o  output  1  word valid, to FIFO src_rdy_i.
- dst_rdy_i  input  1  FIFO can accept, from FIFO dst_rdy_o.
- busy  output  1  high from accepted start through end of gap.
- done  output  1  one-cycle pulse after the EOF word transfers.
- frame_count  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE.
  - dataout=0, src_rdy_o=0, busy=0, done=0, frame_count=0.
  - Internal length, byte counter, seed and err latches are 0.
- clear (synchronous, highest priority after reset): same values as reset on the next edge. Any in-progress frame is abandoned without EOF.
- All outputs are registered.
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 is accepted and latches frame_len, seed and err_inject.
  - frame_len=0 is treated as 1.
  - Next edge: state SEND, busy=1, src_rdy_o=1, dataout = first word.
  - Latency from start to the first valid word is 1 cycle.
- SEND:
  - A transfer occurs on an edge where src_rdy_o=1 and dst_rdy_i=1.
  - While src_rdy_o=1 and dst_rdy_i=0, dataout is held stable.
  - Word k (k=0..L-1):
    - payload = (seed + k) mod 256.
    - SOF = (k==0).
    - EOF = (k==L-1).
    - error = err latch AND (k==L-1).
  - L=1 gives a single word with both SOF and EOF set.
  - After a transfer of a non-EOF word, the next word is presented on the following cycle with no bubble (back-to-back at 1 word/cycle when dst_rdy_i stays high).
  - On transfer of the EOF word, on the next edge:
    - src_rdy_o=0.
    - done=1 for one cycle.
    - frame_count increments.
    - state becomes GAP, or IDLE if GAP_CYCLES=0.
- GAP:
  - src_rdy_o=0 and busy=1 for exactly GAP_CYCLES cycles, then IDLE with busy=0.
  - start during GAP is ignored.
- start asserted while busy=1 is ignored; no queuing.
- Byte counter width is LEN_W. The maximum frame length is 2^LEN_W-1.
- dst_rdy_i toggling is legal at any cycle. The generator never deasserts src_rdy_o mid-frame on its own.
- frame_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then start with frame_len=4, seed=0xFE, err_inject=0, dst_rdy_i=1 -> starting 1 cycle after start, words on 4 consecutive cycles: 0x1FE, 0x0FF, 0x000, 0x201; done pulses once; frame_count=1; busy low GAP_CYCLES cycles after done.
- frame_len=1, seed=0x55, err_inject=1 -> single word 0x755; done pulses once.
- frame_len=0 -> behaves as frame_len=1 (SOF and EOF set on one word).
- frame_len=3, seed=0x10, dst_rdy_i alternating 0/1 starting low -> each word held stable while dst_rdy_i=0; sequence 0x110, 0x011, 0x212 transferred; no duplicates or drops.
- Connected to m_fifo_short_w11 with the reader stalled (FIFO fills, dst_rdy_o falls), then released -> reader receives the full frame intact and in order.
- Mid-frame reset pulse, and separately clear=1 at word 2 of 5 -> outputs return to 0 immediately (reset) or next edge (clear); state IDLE; frame_count=0; a subsequent start produces a clean frame beginning with SOF.
- Start while busy, including during GAP -> ignored; frame_count advances by exactly one per accepted start.
